// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, reset constants and encodings for the fetch stage
package inst_fetch_pkg;

  localparam int          PC_BUS   = 16;
  localparam int          INST_BUS = 16;
  localparam logic [15:0] NOP_INST = 16'h0800;
  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IF_BOOT = 2'd0,
    IF_RUN  = 2'd1,
    IF_WAIT = 2'd2
  } if_state_e;

  // Control applied to the IF/ID register each cycle.
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_e;

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch-stage bundle: control inputs, instruction port and IF/ID outputs
interface inst_fetch_if #(
  parameter int PC_W   = inst_fetch_pkg::PC_BUS,
  parameter int INST_W = inst_fetch_pkg::INST_BUS
);
  import inst_fetch_pkg::*;

  logic              stall;
  logic              mem_ready;
  logic              br_taken;
  logic [PC_W-1:0]   br_target;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] inst;
  logic [INST_W-1:0] if_inst;
  logic [PC_W-1:0]   if_pc;
  logic [PC_W-1:0]   if_pc1;
  logic              if_valid;
  logic [15:0]       fetch_cnt;

  modport master (
    input  stall, mem_ready, br_taken, br_target, inst,
    output pc, if_inst, if_pc, if_pc1, if_valid, fetch_cnt
  );

  modport slave (
    output stall, mem_ready, br_taken, br_target, inst,
    input  pc, if_inst, if_pc, if_pc1, if_valid, fetch_cnt
  );

endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// rtl/inst_fetch_if_id_reg.sv - IF/ID pipeline register with hold, load and bubble controls
module if_id_reg #(
  parameter int                PC_W     = inst_fetch_pkg::PC_BUS,
  parameter int                INST_W   = inst_fetch_pkg::INST_BUS,
  parameter logic [INST_W-1:0] NOP_INST = inst_fetch_pkg::NOP_INST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  inst_fetch_pkg::ifid_op_e op,
  input  logic [INST_W-1:0]        ld_inst,
  input  logic [PC_W-1:0]          ld_pc,
  output logic [INST_W-1:0]        if_inst,
  output logic [PC_W-1:0]          if_pc,
  output logic [PC_W-1:0]          if_pc1,
  output logic                     if_valid
);
  import inst_fetch_pkg::*;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_inst  <= NOP_INST;
      if_pc    <= '0;
      if_pc1   <= '0;
      if_valid <= 1'b0;
    end else begin
      case (op)
        IFID_LOAD: begin
          if_inst  <= ld_inst;
          if_pc    <= ld_pc;
          if_pc1   <= ld_pc + PC_W'(1);
          if_valid <= 1'b1;
        end
        // A bubble leaves if_pc/if_pc1 pointing at the last real fetch.
        IFID_BUBBLE: begin
          if_inst  <= NOP_INST;
          if_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - program counter, next-PC selection, fetch FSM and fetch counter
module inst_fetch #(
  parameter int                PC_W     = inst_fetch_pkg::PC_BUS,
  parameter int                INST_W   = inst_fetch_pkg::INST_BUS,
  parameter logic [PC_W-1:0]   RESET_PC = inst_fetch_pkg::RESET_PC,
  parameter logic [INST_W-1:0] NOP_INST = inst_fetch_pkg::NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  import inst_fetch_pkg::*;

  if_state_e       state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     fetch_cnt_q;
  ifid_op_e        ifid_op;

  // Redirect beats stall beats a busy memory port; BOOT never touches IF/ID.
  always_comb begin
    ifid_op = IFID_HOLD;
    if (state_q != IF_BOOT) begin
      if (bus.br_taken)       ifid_op = IFID_BUBBLE;
      else if (bus.stall)     ifid_op = IFID_HOLD;
      else if (!bus.mem_ready) ifid_op = IFID_BUBBLE;
      else                    ifid_op = IFID_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IF_BOOT;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= '0;
    end else begin
      case (state_q)
        IF_BOOT: state_q <= IF_RUN;
        default: begin
          if (bus.br_taken) begin
            pc_q    <= bus.br_target;
            state_q <= IF_RUN;
          end else if (bus.stall) begin
            state_q <= state_q;
          end else if (!bus.mem_ready) begin
            state_q <= IF_WAIT;
          end else begin
            pc_q        <= pc_q + PC_W'(1);
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
            state_q     <= IF_RUN;
          end
        end
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.fetch_cnt = fetch_cnt_q;

  if_id_reg #(
    .PC_W     (PC_W),
    .INST_W   (INST_W),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .op       (ifid_op),
    .ld_inst  (bus.inst),
    .ld_pc    (pc_q),
    .if_inst  (bus.if_inst),
    .if_pc    (bus.if_pc),
    .if_pc1   (bus.if_pc1),
    .if_valid (bus.if_valid)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed vector table plus randomized run against a reference model
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if #(.PC_W(16), .INST_W(16)) bus ();

  inst_fetch #(
    .PC_W(16), .INST_W(16), .RESET_PC(16'h0000), .NOP_INST(16'h0800)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] rom [0:65535];
  assign bus.inst = rom[bus.pc];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_pc, m_inst, m_if_pc, m_if_pc1, m_cnt;
  logic        m_valid;
  if_state_e   m_state;

  typedef struct {
    bit          r;
    bit          s;
    bit          m;
    bit          b;
    logic [15:0] t;
    logic [15:0] pc;
    bit          v;
    logic [15:0] ipc;
    logic [15:0] ipc1;
    logic [15:0] cnt;
    if_state_e   st;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit m, input bit b, input logic [15:0] t);
    if (!r) begin
      m_state = IF_BOOT; m_pc = 16'h0000; m_inst = 16'h0800;
      m_if_pc = 0; m_if_pc1 = 0; m_valid = 0; m_cnt = 0;
    end else if (m_state == IF_BOOT) begin
      m_state = IF_RUN;
    end else if (b) begin
      m_pc = t; m_inst = 16'h0800; m_valid = 0; m_state = IF_RUN;
    end else if (s) begin
      // everything holds
    end else if (!m) begin
      m_inst = 16'h0800; m_valid = 0; m_state = IF_WAIT;
    end else begin
      m_inst = rom[m_pc]; m_if_pc = m_pc; m_if_pc1 = m_pc + 16'd1;
      m_valid = 1; m_pc = m_pc + 16'd1; m_cnt = m_cnt + 16'd1; m_state = IF_RUN;
    end
  endtask

  task automatic apply(input bit r, input bit s, input bit m, input bit b, input logic [15:0] t);
    rst = r; bus.stall = s; bus.mem_ready = m; bus.br_taken = b; bus.br_target = t;
    model_step(r, s, m, b, t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_inst;
    bus.stall = 0; bus.mem_ready = 1; bus.br_taken = 0; bus.br_target = 0;
    for (int a = 0; a < 65536; a++) rom[a] = 16'($urandom);
    rom[0] = 16'h6801; rom[1] = 16'h6902; rom[2] = 16'h6A01;

    //                r  s  m  b  tgt       pc        v  if_pc     if_pc1    cnt  state
    vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0, IF_BOOT});
    vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0, IF_RUN});
    vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0001, 1, 16'h0000, 16'h0001, 16'd1, IF_RUN});
    vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0002, 1, 16'h0001, 16'h0002, 16'd2, IF_RUN});
    vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0003, 1, 16'h0002, 16'h0003, 16'd3, IF_RUN});
    vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0004, 1, 16'h0003, 16'h0004, 16'd4, IF_RUN});
    vecs.push_back('{1, 1, 1, 0, 16'h0000, 16'h0004, 1, 16'h0003, 16'h0004, 16'd4, IF_RUN});
    vecs.push_back('{1, 1, 1, 0, 16'h0000, 16'h0004, 1, 16'h0003, 16'h0004, 16'd4, IF_RUN});
    vecs.push_back('{1, 1, 1, 0, 16'h0000, 16'h0004, 1, 16'h0003, 16'h0004, 16'd4, IF_RUN});
    vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0005, 1, 16'h0004, 16'h0005, 16'd5, IF_RUN});
    vecs.push_back('{1, 0, 1, 1, 16'h0002, 16'h0002, 0, 16'h0004, 16'h0005, 16'd5, IF_RUN});
    vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0003, 1, 16'h0002, 16'h0003, 16'd6, IF_RUN});
    vecs.push_back('{1, 1, 0, 1, 16'h0007, 16'h0007, 0, 16'h0002, 16'h0003, 16'd6, IF_RUN});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0007, 0, 16'h0002, 16'h0003, 16'd6, IF_WAIT});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0007, 0, 16'h0002, 16'h0003, 16'd6, IF_WAIT});
    vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0008, 1, 16'h0007, 16'h0008, 16'd7, IF_RUN});
    vecs.push_back('{1, 0, 1, 1, 16'hFFFF, 16'hFFFF, 0, 16'h0007, 16'h0008, 16'd7, IF_RUN});
    vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0000, 1, 16'hFFFF, 16'h0000, 16'd8, IF_RUN});
    vecs.push_back('{0, 1, 0, 1, 16'h0055, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0, IF_BOOT});
    vecs.push_back('{1, 0, 1, 1, 16'h0055, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0, IF_RUN});
    vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0001, 1, 16'h0000, 16'h0001, 16'd1, IF_RUN});

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].s, vecs[i].m, vecs[i].b, vecs[i].t);
      exp_inst = vecs[i].v ? rom[vecs[i].ipc] : 16'h0800;
      chk($sformatf("vec%0d pc", i),        32'(bus.pc),        32'(vecs[i].pc));
      chk($sformatf("vec%0d if_valid", i),  32'(bus.if_valid),  32'(vecs[i].v));
      chk($sformatf("vec%0d if_pc", i),     32'(bus.if_pc),     32'(vecs[i].ipc));
      chk($sformatf("vec%0d if_pc1", i),    32'(bus.if_pc1),    32'(vecs[i].ipc1));
      chk($sformatf("vec%0d if_inst", i),   32'(bus.if_inst),   32'(exp_inst));
      chk($sformatf("vec%0d fetch_cnt", i), 32'(bus.fetch_cnt), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d state", i),     32'(dut.state_q),   32'(vecs[i].st));
    end

    // The first real fetch after reset must be the LI R1 1 word.
    chk("boot_word", 32'(vecs[2].v ? rom[16'h0000] : 16'h0000), 32'(16'h6801));

    for (int c = 0; c < 3000; c++) begin
      bit r, s, m, b;
      logic [15:0] t;
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 4) != 0);
      b = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1)) : 16'($urandom);
      apply(r, s, m, b, t);
      chk("rnd pc",        32'(bus.pc),        32'(m_pc));
      chk("rnd if_valid",  32'(bus.if_valid),  32'(m_valid));
      chk("rnd if_pc",     32'(bus.if_pc),     32'(m_if_pc));
      chk("rnd if_pc1",    32'(bus.if_pc1),    32'(m_if_pc1));
      chk("rnd if_inst",   32'(bus.if_inst),   32'(m_inst));
      chk("rnd fetch_cnt", 32'(bus.fetch_cnt), 32'(m_cnt));
      chk("rnd state",     32'(dut.state_q),   32'(m_state));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
